// File: rtl/dmem_pkg.sv
// Shared definitions for the MIPS data-memory stage: access sizes, FSM state
// encodings and the byte-lane / extension helpers used by dmem_ctrl.
package dmem_pkg;

  // Access sizes; the encoding 3 is handled as a word everywhere.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Controller FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Byte-lane write enables for a store of the given size at address low bits lo.
  // Halfwords only look at lo[1], so misaligned halves truncate to their lane pair.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data into every lane it could land in.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: lane_data = {4{wdata[7:0]}};
      SZ_HALF: lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  // Pick the addressed lane(s) out of a read word and sign/zero extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic [1:0] lo, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lo, 3'b000} +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: load_extend = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = rdata;
    endcase
  endfunction

  // True when a half or word access is not naturally aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 data RAM with per-byte write enables and a registered
// read port. Contents are never reset; the read register holds its value until
// the next enabled read, which lets the controller present it for a whole response.
module dmem_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // One access per enabled cycle: byte-masked write, or a read into rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
        for (int i = 0; i < 4; i++) begin
          if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MIPS data-memory stage: captures one request at a time, waits WAIT_CYCLES,
// performs the byte/half/word load or store, and holds the writeback value
// (extended load data or the ALU result) until the consumer takes it.
// Optional macro: DMEM_ALIGN_CHECK_EN -- misaligned half/word accesses are
// suppressed and flagged on resp_err; otherwise low address bits truncate.
// INIT_ZERO is accepted for interface compatibility only: the array is never
// preloaded, so reading a word that was never written returns undefined data.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic        req_mem_to_reg,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_wb_data,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  // Reject parameter values the counter and address split cannot represent.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || DEPTH < 4 || (1 << AW) != DEPTH ||
      INIT_ZERO < 0 || INIT_ZERO > 1) begin : g_bad_param
    $error("dmem_ctrl: unsupported parameter value");
  end

  logic [1:0]  state_reg;
  logic [3:0]  count_reg;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        sgn_reg;
  logic        m2r_reg;
  logic        do_mem_reg;
  logic        err_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  logic        accept;
  logic        req_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] wb_next;

  assign accept = req_valid & (state_reg == ST_IDLE);

  // Alignment faults only apply to real memory accesses, not pass-through ALU results.
`ifdef DMEM_ALIGN_CHECK_EN
  assign req_err = (req_we | req_mem_to_reg) & misaligned(req_size, req_addr[1:0]);
`else
  assign req_err = 1'b0;
`endif

  // FSM and request capture; an asynchronous reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      count_reg  <= 4'd0;
      we_reg     <= 1'b0;
      size_reg   <= SZ_BYTE;
      sgn_reg    <= 1'b0;
      m2r_reg    <= 1'b0;
      do_mem_reg <= 1'b0;
      err_reg    <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg  <= ST_ACCESS;
            count_reg  <= 4'(WAIT_CYCLES);
            we_reg     <= req_we;
            size_reg   <= req_size;
            sgn_reg    <= req_signed;
            m2r_reg    <= req_mem_to_reg;
            do_mem_reg <= (req_we | req_mem_to_reg) & ~req_err;
            err_reg    <= req_err;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
          end
        end
        ST_ACCESS: begin
          if (count_reg == 4'd0) state_reg <= ST_RESP;
          else                   count_reg <= count_reg - 4'd1;
        end
        ST_RESP: begin
          if (resp_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // The RAM is touched only on the last ACCESS cycle, so a reset earlier drops the store.
  assign ram_en = (state_reg == ST_ACCESS) && (count_reg == 4'd0) && do_mem_reg;
  assign ram_we = we_reg ? byte_en(size_reg, addr_reg[1:0]) : 4'b0000;

  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_reg[AW+1:2]),
    .wdata (lane_data(size_reg, wdata_reg)),
    .rdata (ram_rdata)
  );

  // Writeback select: faulted -> 0, load -> extended RAM data, anything else -> address.
  always_comb begin
    wb_next = addr_reg;
    if (err_reg)                wb_next = 32'd0;
    else if (m2r_reg & ~we_reg) wb_next = load_extend(ram_rdata, size_reg, addr_reg[1:0], sgn_reg);
  end

  assign req_ready    = (state_reg == ST_IDLE);
  assign resp_valid   = (state_reg == ST_RESP);
  assign resp_wb_data = resp_valid ? wb_next : 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
  assign resp_err     = resp_valid & err_reg;
`else
  assign resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed load/store/extension cases, latency and hold
// checks, aliasing, reset during an access, then randomized traffic checked
// against a byte-addressed memory model. Honours DMEM_ALIGN_CHECK_EN.
module tb_dmem_ctrl;

  localparam int DEPTH = 1024;
  localparam int WAIT  = 3;
  localparam int NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic        req_mem_to_reg = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_wb_data;
  logic        resp_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mb [NBYTE];

  dmem_ctrl #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT),
    .INIT_ZERO   (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_mem_to_reg (req_mem_to_reg),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_wb_data   (resp_wb_data),
    .resp_err       (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte-addressed memory model: a store writes n little-endian bytes, a load
  // gathers n bytes and extends; upper address bits wrap modulo the array size.
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic m2r, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] wb, output logic err);
    int n;
    int base;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = int'(addr % NBYTE) & ~(n - 1);
    err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((we || m2r) && (addr % n) != 0) err = 1'b1;
`endif
    if (err) begin
      wb = 32'd0;
    end else if (we) begin
      for (int i = 0; i < n; i++) mb[base + i] = wdata[8*i +: 8];
      wb = addr;
    end else if (!m2r) begin
      wb = addr;
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
      if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      wb = v;
    end
  endfunction

  // One full handshake: issue, count latency, optionally stall the consumer, retire.
  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic m2r, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_wb, input logic exp_err, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_mem_to_reg = m2r; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Inputs are don't-care once accepted; scramble them to catch late sampling.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_mem_to_reg = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      check({tag, ".busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(WAIT + 1));
    check({tag, ".wb"}, resp_wb_data, exp_wb);
    check({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hold_wb"}, resp_wb_data, exp_wb);
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, ".retired"}, 32'(resp_valid), 32'd0);
    check({tag, ".ready_again"}, 32'(req_ready), 32'd1);
    $display("[TB] %s we=%0d size=%0d sgn=%0d m2r=%0d addr=%08h wdata=%08h -> wb=%08h err=%0d lat=%0d",
             tag, we, size, sgn, m2r, addr, wdata, resp_wb_data, resp_err, lat);
  endtask

  // Directed: literal expectation, model kept in step.
  task automatic dx(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                    input logic m2r, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_wb, input logic exp_err, input int hold);
    logic [31:0] mwb;
    logic        merr;
    model(we, size, sgn, m2r, addr, wdata, mwb, merr);
    xact(tag, we, size, sgn, m2r, addr, wdata, exp_wb, exp_err, hold);
  endtask

  // Randomized: expectation from the model.
  task automatic mx(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                    input logic m2r, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic [31:0] mwb;
    logic        merr;
    model(we, size, sgn, m2r, addr, wdata, mwb, merr);
    xact(tag, we, size, sgn, m2r, addr, wdata, mwb, merr, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_wb_data", resp_wb_data, 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.req_ready", 32'(req_ready), 32'd1);
    check("idle.resp_valid", 32'(resp_valid), 32'd0);

    // Loads and stores of each size with extension
    dx("sw10",  1'b1, 2'd2, 1'b0, 1'b1, 32'h10, 32'h8899AABB, 32'h10, 1'b0, 0);
    dx("lw10",  1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 0);
    dx("lb13",  1'b0, 2'd0, 1'b1, 1'b1, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 0);
    dx("lbu13", 1'b0, 2'd0, 1'b0, 1'b1, 32'h13, 32'h0, 32'h00000088, 1'b0, 0);
    dx("lh10",  1'b0, 2'd1, 1'b1, 1'b1, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 0);
    dx("sb11",  1'b1, 2'd0, 1'b0, 1'b0, 32'h11, 32'hFFFFFF55, 32'h11, 1'b0, 0);
    dx("lw10b", 1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'h0, 32'h889955BB, 1'b0, 0);
    dx("sh12",  1'b1, 2'd1, 1'b0, 1'b0, 32'h12, 32'hABCD1234, 32'h12, 1'b0, 0);
    dx("lw10c", 1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'h0, 32'h123455BB, 1'b0, 5);

    // Pass-through ALU result leaves memory alone
    dx("alu",   1'b0, 2'd2, 1'b0, 1'b0, 32'hDEADBEEC, 32'hFFFFFFFF, 32'hDEADBEEC, 1'b0, 0);
    dx("lw10d", 1'b0, 2'd2, 1'b0, 1'b1, 32'h10, 32'h0, 32'h123455BB, 1'b0, 0);

    // Aliasing: upper address bits beyond the array are ignored
    dx("sw0",    1'b1, 2'd2, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    dx("lw1000", 1'b0, 2'd2, 1'b0, 1'b1, 32'h1000, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    // Reset during ACCESS discards the store
    dx("sw20", 1'b1, 2'd2, 1'b0, 1'b1, 32'h20, 32'h0BADC0DE, 32'h20, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_mem_to_reg = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort.req_ready", 32'(req_ready), 32'd1);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.resp_wb_data", resp_wb_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort.still_idle", 32'(resp_valid), 32'd0);
    dx("lw20", 1'b0, 2'd2, 1'b0, 1'b1, 32'h20, 32'h0, 32'h0BADC0DE, 1'b0, 0);

    // Misaligned accesses
`ifdef DMEM_ALIGN_CHECK_EN
    dx("lw22", 1'b0, 2'd2, 1'b0, 1'b1, 32'h22, 32'h0, 32'h0, 1'b1, 1);
    dx("sh21", 1'b1, 2'd1, 1'b0, 1'b0, 32'h21, 32'h7777, 32'h0, 1'b1, 0);
    dx("lw20b", 1'b0, 2'd2, 1'b0, 1'b1, 32'h20, 32'h0, 32'h0BADC0DE, 1'b0, 0);
`else
    dx("lw22", 1'b0, 2'd2, 1'b0, 1'b1, 32'h22, 32'h0, 32'h0BADC0DE, 1'b0, 1);
    dx("lh21", 1'b0, 2'd1, 1'b1, 1'b1, 32'h21, 32'h0, 32'hFFFFC0DE, 1'b0, 0);
`endif

    // Randomized traffic over 16 words that the model knows
    for (int i = 0; i < 16; i++)
      mx("fill", 1'b1, 2'd2, 1'b0, 1'b1, 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      mx("rand", 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), a, $urandom,
         int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
